bram_port_arbiter: RTL

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter_pkg.sv | 23 ++
 rtl/bram_port_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// rtl/bram_port_arbiter_pkg.sv - shared widths, requester index encoding and arbitration helper
package bram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 16;

    typedef enum logic {
        REQ_IDX_0 = 1'b0,
        REQ_IDX_1 = 1'b1
    } req_idx_e;

    // Winner of a conflict: fixed priority favours requester 0, otherwise
    // the requester that did not get the previous grant.
    function automatic req_idx_e conflict_winner(input req_idx_e last_gnt,
                                                 input logic     fixed_prio);
        if (fixed_prio) begin
            return REQ_IDX_0;
        end
        return (last_gnt == REQ_IDX_0) ? REQ_IDX_1 : REQ_IDX_0;
    endfunction

endpackage

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester arbiter in front of a single registered-read BRAM port
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_q,
    output logic [CNT_W-1:0]  conflict_cnt
);

    req_idx_e             last_gnt_q, last_gnt_d;
    logic                 rd_pend_q, rd_pend_d;
    req_idx_e             rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 gnt_valid;
    req_idx_e             gnt_idx;
    logic                 gnt_we;
    logic                 conflict;

    assign conflict = req0 && req1;

    // Grants are forced low while reset is held so nothing reaches the BRAM.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = REQ_IDX_0;
        if (rst) begin
            if (conflict) begin
                gnt_valid = 1'b1;
                gnt_idx   = conflict_winner(last_gnt_q, FIXED_PRIO != 0);
            end else if (req0) begin
                gnt_valid = 1'b1;
                gnt_idx   = REQ_IDX_0;
            end else if (req1) begin
                gnt_valid = 1'b1;
                gnt_idx   = REQ_IDX_1;
            end
        end
    end

    assign gnt0      = gnt_valid && (gnt_idx == REQ_IDX_0);
    assign gnt1      = gnt_valid && (gnt_idx == REQ_IDX_1);
    assign gnt_we    = (gnt_idx == REQ_IDX_1) ? we1 : we0;
    assign bram_addr = (gnt_idx == REQ_IDX_1) ? addr1 : addr0;
    assign bram_data = (gnt_idx == REQ_IDX_1) ? wdata1 : wdata0;
    assign bram_we   = gnt_valid && gnt_we;

    always_comb begin
        last_gnt_d = last_gnt_q;
        rd_pend_d  = gnt_valid && !gnt_we;
        rd_owner_d = gnt_idx;
        cnt_d      = cnt_q;
        if (gnt_valid) begin
            last_gnt_d = gnt_idx;
        end
        if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // last_gnt resets to requester 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_gnt_q <= REQ_IDX_1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= REQ_IDX_0;
            cnt_q      <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            cnt_q      <= cnt_d;
        end
    end

    // A read granted just before reset must not surface while reset is low.
    assign rvalid0      = rst && rd_pend_q && (rd_owner_q == REQ_IDX_0);
    assign rvalid1      = rst && rd_pend_q && (rd_owner_q == REQ_IDX_1);
    assign rdata0       = bram_q;
    assign rdata1       = bram_q;
    assign conflict_cnt = cnt_q;

endmodule
